// File: rtl/hamming13_encoder.sv
// Streaming (13,8) block encoder with optional single-bit error injection and a
// 2-entry output FIFO. Check bits match the downstream syndrome decoder; d7 is uncovered.
module hamming13_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  d,
  input  logic        inj_en,
  input  logic [3:0]  inj_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] cx,
  output logic [7:0]  word_count,
  output logic [7:0]  inj_count
);

  function automatic logic [12:0] encode(input logic [7:0] w);
    logic [4:0] chk;
    chk[0] = w[0] ^ w[1] ^ w[2] ^ w[4] ^ w[5] ^ w[6];
    chk[1] = w[0] ^ w[1] ^ w[6];
    chk[2] = w[4] ^ w[6];
    chk[3] = w[2] ^ w[3] ^ w[4];
    chk[4] = w[0];
    return {chk, w};
  endfunction

  logic [12:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;

  logic        push;
  logic        pop;
  logic        inj_hit;
  logic [12:0] flip_mask;
  logic [12:0] push_word;

  // in_ready depends only on occupancy, so there is no path from out_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign cx        = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Positions 13..15 fall outside the codeword and leave it clean.
  assign inj_hit   = inj_en && (inj_pos <= 4'd12);
  assign flip_mask = inj_hit ? (13'd1 << inj_pos) : 13'd0;
  assign push_word = encode(d) ^ flip_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset too, because cx must read 0 straight out of reset.
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      word_count <= 8'd0;
      inj_count  <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
        word_count  <= word_count + 8'd1;
        if (inj_hit) inj_count <= inj_count + 8'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming13_encoder.sv
// Randomized bench for hamming13_encoder: queue-based reference model, per-cycle
// compare process, directed literal checks, and a syndrome-decoder loopback.
module tb_hamming13_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  d;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] cx;
  logic [7:0]  word_count;
  logic [7:0]  inj_count;

  always #5 clk = ~clk;

  hamming13_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cx        (cx),
    .word_count(word_count),
    .inj_count (inj_count)
  );

  typedef struct {
    logic [12:0] cw;
    logic [7:0]  data;
    bit          decodable;
  } entry_t;

  entry_t     q[$];
  logic [7:0] m_wc;
  logic [7:0] m_ic;
  bit         cmp_on = 1'b0;
  int         total  = 0;
  int         bad    = 0;

  // Each check bit is the parity of the data bits selected by its mask.
  localparam logic [7:0] MASKS [5] = '{8'h77, 8'h43, 8'h50, 8'h1C, 8'h01};

  function automatic logic [12:0] model_encode(input logic [7:0] w);
    logic [12:0] r;
    r[7:0] = w;
    for (int k = 0; k < 5; k++) r[8+k] = ^(w & MASKS[k]);
    return r;
  endfunction

  // Syndrome decoder: recompute checks, match syndrome to a data-bit column.
  function automatic logic [7:0] model_decode(input logic [12:0] c);
    logic [4:0]  syn;
    logic [12:0] col;
    logic [7:0]  fixed;
    logic [7:0]  one;
    fixed = c[7:0];
    syn   = c[12:8] ^ model_encode(c[7:0]) >> 8;
    for (int b = 0; b < 7; b++) begin
      one = 8'd1 << b;
      col = model_encode(one);
      if (syn != 5'd0 && syn == col[12:8]) fixed[b] = ~fixed[b];
    end
    return fixed;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: advances on every rising edge from the inputs alone.
  initial begin
    bit     push, pop;
    entry_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_wc = 8'd0;
        m_ic = 8'd0;
      end else begin
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (push) begin
          e.data      = d;
          e.cw        = model_encode(d);
          e.decodable = 1'b1;
          if (inj_en && inj_pos <= 4'd12) begin
            e.cw[inj_pos] = ~e.cw[inj_pos];
            m_ic++;
            e.decodable = (inj_pos <= 4'd6);
          end
          q.push_back(e);
          m_wc++;
        end
      end
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(q.size() != 2));
      check("word_count", 32'(word_count), 32'(m_wc));
      check("inj_count", 32'(inj_count), 32'(m_ic));
      if (q.size() != 0) begin
        check("cx", 32'(cx), 32'(q[0].cw));
        if (q[0].decodable) check("loopback", 32'(model_decode(cx)), 32'(q[0].data));
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0; d = 8'h00; inj_en = 1'b0; inj_pos = 4'd0;
  endtask

  task automatic offer(input logic [7:0] w, input logic ie, input logic [3:0] ip);
    in_valid = 1'b1; d = w; inj_en = ie; inj_pos = ip;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    offer(8'hA5, 1'b1, 4'd2);
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  localparam logic [7:0]  DIR_D  [4] = '{8'h00, 8'h01, 8'hFF, 8'h10};
  localparam logic [12:0] DIR_CX [4] = '{13'h0000, 13'h1301, 13'h1AFF, 13'h0D10};

  initial begin
    rst = 1'b1; out_ready = 1'b0; idle();
    @(negedge clk);
    cmp_on = 1'b1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_cx", 32'(cx), 32'h0000);
    check("model_pin_ff", 32'(model_encode(DIR_D[2])), 32'(DIR_CX[2]));
    rst = 1'b0;

    // Directed encode, one cycle latency each.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(DIR_D[i], 1'b0, 4'd0);
      @(negedge clk);
      check("dir_cx", 32'(cx), 32'(DIR_CX[i]));
    end
    idle();
    @(negedge clk);
    check("dir_word_count", 32'(word_count), 32'd4);

    // Injection in range, then out of range.
    do_reset();
    offer(8'h01, 1'b1, 4'd3);
    @(negedge clk);
    check("inj_cx", 32'(cx), 32'h1309);
    check("inj_count", 32'(inj_count), 32'd1);
    offer(8'h01, 1'b1, 4'd14);
    @(negedge clk);
    check("inj14_cx", 32'(cx), 32'h1301);
    check("inj14_count", 32'(inj_count), 32'd1);
    idle();
    @(negedge clk);

    // Backpressure: three words offered with the sink stalled.
    do_reset();
    out_ready = 1'b0;
    offer(8'h01, 1'b0, 4'd0); @(negedge clk);
    offer(8'hFF, 1'b0, 4'd0); @(negedge clk);
    offer(8'h10, 1'b0, 4'd0); @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(cx), 32'h1301);
    check("bp_count", 32'(word_count), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_ready", 32'(in_ready), 32'd1);
    check("bp_pop1_head", 32'(cx), 32'h1AFF);
    @(negedge clk);
    idle();
    check("bp_pushpop_head", 32'(cx), 32'h0D10);
    check("bp_pushpop_count", 32'(word_count), 32'd3);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two words buffered.
    out_ready = 1'b0;
    offer(8'h3C, 1'b0, 4'd0); @(negedge clk);
    offer(8'hC3, 1'b1, 4'd5); @(negedge clk);
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_inj_count", 32'(inj_count), 32'd0);

    // Random traffic with random injection positions.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      d         = 8'($urandom);
      inj_en    = 1'($urandom_range(0, 1));
      inj_pos   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    // Decoder loopback with a single error in bits 0..6.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      offer(8'($urandom), 1'b1, 4'($urandom_range(0, 6)));
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);

    // Counter wrap: 256 sustained accepts.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      offer(8'($urandom), 1'b0, 4'd0);
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    check("wrap_word_count", 32'(word_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
